// File: rtl/uart_tx_frame_pkg.sv
// Shared UART TX/RX definitions: default word width, FSM state codes and parity type encoding.
package uart_tx_frame_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

endpackage

// File: rtl/uart_tx_frame_par_calc.sv
// Combinational parity bit for the latched TX word; same convention as the RX checker.
module tx_par_calc
  import uart_tx_frame_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_type_i,
  output logic             par_o
);

  // Even type: bit makes the total count of ones even; odd type inverts it.
  assign par_o = (^data_i) ^ (par_type_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, WIDTH data bits LSB first, optional parity, one stop bit.
// One serial bit per i_clk cycle; o_tx and o_busy come straight from registers.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  input  logic             i_par_en,
  input  logic             i_par_type,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  tx_state_e        state_q;
  logic [WIDTH-1:0] data_q;
  logic             par_en_q;
  logic             par_type_q;
  logic [CW-1:0]    cnt_q;
  logic             tx_q;
  logic             busy_q;
  logic             par_bit;

  tx_par_calc #(.WIDTH(WIDTH)) u_par_calc (
    .data_i     (data_q),
    .par_type_i (par_type_q),
    .par_o      (par_bit)
  );

  // tx_q is loaded with the bit for the state being entered, so cnt_q always
  // names the data bit currently on the line.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_data_valid) begin
            data_q     <= i_data;
            par_en_q   <= i_par_en;
            par_type_q <= i_par_type;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          tx_q    <= data_q[0];
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            if (par_en_q) begin
              tx_q    <= par_bit;
              state_q <= ST_PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            tx_q  <= data_q[cnt_q + 1'b1];
          end
        end
        ST_PARITY: begin
          tx_q    <= 1'b1;
          state_q <= ST_STOP;
        end
        ST_STOP: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a queue-of-bits line model checked every cycle plus directed frame captures.
module tb_uart_tx_frame;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] data;
  logic         data_valid;
  logic         par_en;
  logic         par_type;
  logic         tx;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;

  uart_tx_frame #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (data_valid),
    .i_par_en     (par_en),
    .i_par_type   (par_type),
    .o_tx         (tx),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line model: the bits still to appear on the line for the frame in flight.
  logic line_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q.delete();
    end else if (line_q.size() != 0) begin
      void'(line_q.pop_front());
    end else if (data_valid) begin
      int ones;
      ones = $countones(data);
      line_q.push_back(1'b0);
      for (int i = 0; i < W; i++) line_q.push_back(data[i]);
      if (par_en) begin
        if (par_type) line_q.push_back((ones % 2) == 0);
        else          line_q.push_back((ones % 2) == 1);
      end
      line_q.push_back(1'b1);
    end
  end

  always @(negedge clk) begin
    logic exp_tx;
    exp_tx = (line_q.size() != 0) ? line_q[0] : 1'b1;
    chk("tx_line", {31'd0, tx}, {31'd0, exp_tx});
    chk("busy_line", {31'd0, busy}, {31'd0, line_q.size() != 0});
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Returns at the negedge where the start bit is on the line.
  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    @(negedge clk);
    data       = d;
    par_en     = pe;
    par_type   = pt;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [15:0] seq, output int busy_cnt);
    seq = '0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      seq = {seq[14:0], tx};
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    if (busy) busy_cnt++;
  endtask

  logic [15:0] seq;
  int          bc;
  int          gap;

  initial begin
    rst        = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_type   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send(8'hA5, 1'b1, 1'b0);
    capture(11, seq, bc);
    chk("a5_even_seq", {16'd0, seq}, {16'd0, 16'b00000_01010010101});
    chk("a5_busy_len", bc, 11);

    wait_idle();
    send(8'h07, 1'b1, 1'b1);
    capture(11, seq, bc);
    chk("07_odd_seq", {16'd0, seq}, {16'd0, 16'b00000_01110000001});

    wait_idle();
    send(8'h07, 1'b1, 1'b0);
    capture(11, seq, bc);
    chk("07_even_seq", {16'd0, seq}, {16'd0, 16'b00000_01110000011});

    wait_idle();
    send(8'h3C, 1'b0, 1'b0);
    capture(10, seq, bc);
    chk("3c_nopar_seq", {16'd0, seq}, {16'd0, 16'b000000_0001111001});
    chk("3c_busy_len", bc, 10);

    // Input changes and a fresh request during the 3rd data bit must be ignored.
    wait_idle();
    send(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    data       = 8'hFF;
    par_en     = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      chk("no_second_frame", {31'd0, busy}, 32'd0);
    end

    // Valid held high across two words.
    @(negedge clk);
    data       = 8'h5A;
    par_en     = 1'b1;
    par_type   = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    data = 8'hC3;
    bc = 0;
    while (busy && bc < 40) begin
      @(negedge clk);
      bc++;
    end
    gap = 0;
    while (!busy && gap < 40) begin
      gap++;
      chk("b2b_gap_idle_high", {31'd0, tx}, 32'd1);
      @(negedge clk);
    end
    chk("b2b_gap", gap, 1);
    data_valid = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    send(8'h96, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hA5, 1'b1, 1'b0);
    capture(11, seq, bc);
    chk("post_rst_seq", {16'd0, seq}, {16'd0, 16'b00000_01010010101});
    chk("post_rst_busy_len", bc, 11);

    // Random traffic; inputs wiggle every cycle, including mid-frame.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data       = W'($urandom);
      par_en     = 1'($urandom);
      par_type   = 1'($urandom);
      data_valid = ($urandom_range(0, 9) < 3);
    end
    data_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
